// File: rtl/bsg_fpu_minmax_reduce.sv
// FP min/max compare and the streaming min/max reduction stage built on it.
// Ordering keys make -0 sort below +0; NaN operands fall back to the other operand.

// bsg_fpu_cmp: IEEE minNum/maxNum of two floats; sNaN on either input flags invalid.
// Latency: combinational.
// Backpressure: none (pure function of a_i/b_i).
module bsg_fpu_cmp #(
  parameter int e_p = 5,
  parameter int m_p = 10
) (
  input  logic [e_p+m_p:0] a_i,
  input  logic [e_p+m_p:0] b_i,
  output logic [e_p+m_p:0] min_o,
  output logic [e_p+m_p:0] max_o,
  output logic             min_max_invalid_o
);
  localparam int w_lp = 1 + e_p + m_p;
  localparam logic [w_lp-1:0] qnan_lp = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

  logic a_nan, b_nan, a_snan, b_snan, a_lt_b;
  logic [w_lp-1:0] a_key, b_key;

  assign a_nan  = (&a_i[w_lp-2:m_p]) & (|a_i[m_p-1:0]);
  assign b_nan  = (&b_i[w_lp-2:m_p]) & (|b_i[m_p-1:0]);
  assign a_snan = a_nan & ~a_i[m_p-1];
  assign b_snan = b_nan & ~b_i[m_p-1];

  // Sign-magnitude to unsigned order: negatives invert, positives get the top bit set.
  assign a_key  = a_i[w_lp-1] ? ~a_i : {1'b1, a_i[w_lp-2:0]};
  assign b_key  = b_i[w_lp-1] ? ~b_i : {1'b1, b_i[w_lp-2:0]};
  assign a_lt_b = a_key < b_key;

  assign min_max_invalid_o = a_snan | b_snan;

  always_comb begin
    min_o = a_lt_b ? a_i : b_i;
    max_o = a_lt_b ? b_i : a_i;
    if (a_nan & b_nan) begin
      min_o = qnan_lp;
      max_o = qnan_lp;
    end else if (a_nan) begin
      min_o = b_i;
      max_o = b_i;
    end else if (b_nan) begin
      min_o = a_i;
      max_o = a_i;
    end
  end
endmodule

// bsg_fpu_minmax_reduce: running min/max/invalid/count over a stream of floats.
// Latency: result valid one cycle after the element tagged last is accepted.
// Backpressure: ready_o drops while a result waits for yumi_i; one element per cycle otherwise.
module bsg_fpu_minmax_reduce #(
  parameter int e_p           = 5,
  parameter int m_p           = 10,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [e_p+m_p:0]         data_i,
  input  logic                     last_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [e_p+m_p:0]         min_o,
  output logic [e_p+m_p:0]         max_o,
  output logic                     invalid_o,
  output logic [count_width_p-1:0] count_o,
  input  logic                     yumi_i
);
  localparam int width_lp = 1 + e_p + m_p;
  localparam logic [width_lp-1:0] qnan_lp = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};

  typedef enum logic {e_accum, e_done} state_e;

  state_e                   state_r;
  logic [width_lp-1:0]      min_r, max_r;
  logic                     invalid_r;
  logic [count_width_p-1:0] count_r;

  logic [width_lp-1:0] min_n, max_n, min_unused, max_unused;
  logic                min_inv, max_inv;

  // Accumulator is operand a, the incoming element operand b.
  bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) cmp_min (
    .a_i(min_r), .b_i(data_i), .min_o(min_n), .max_o(max_unused),
    .min_max_invalid_o(min_inv)
  );

  bsg_fpu_cmp #(.e_p(e_p), .m_p(m_p)) cmp_max (
    .a_i(max_r), .b_i(data_i), .min_o(min_unused), .max_o(max_n),
    .min_max_invalid_o(max_inv)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_accum;
      min_r     <= qnan_lp;
      max_r     <= qnan_lp;
      invalid_r <= 1'b0;
      count_r   <= '0;
    end else begin
      case (state_r)
        e_accum: if (v_i) begin
          min_r     <= min_n;
          max_r     <= max_n;
          invalid_r <= invalid_r | min_inv | max_inv;
          if (~&count_r) count_r <= count_r + count_width_p'(1);
          if (last_i) state_r <= e_done;
        end
        e_done: if (yumi_i) begin
          state_r   <= e_accum;
          min_r     <= qnan_lp;
          max_r     <= qnan_lp;
          invalid_r <= 1'b0;
          count_r   <= '0;
        end
        default: state_r <= e_accum;
      endcase
    end
  end

  assign ready_o   = (state_r == e_accum);
  assign v_o       = (state_r == e_done);
  assign min_o     = min_r;
  assign max_o     = max_r;
  assign invalid_o = invalid_r;
  assign count_o   = count_r;
endmodule

// File: tb/tb_bsg_fpu_minmax_reduce.sv
// Self-checking bench: directed reduction table, handshake corner sequences, random streams vs a real-valued model.
module tb_bsg_fpu_minmax_reduce;
  logic        clk = 1'b0;
  logic        reset_i, v_i, last_i, yumi_i;
  logic [15:0] data_i;
  logic        ready_o, v_o, invalid_o;
  logic [15:0] min_o, max_o, count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_fpu_minmax_reduce dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .v_o(v_o), .min_o(min_o), .max_o(max_o),
    .invalid_o(invalid_o), .count_o(count_o), .yumi_i(yumi_i)
  );

  typedef struct {
    int               n;
    logic [3:0][15:0] d;
    logic [15:0]      emin, emax;
    logic             einv;
    int               ecnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // yumi is only legal while a result is presented.
  always @(posedge clk) begin
    if (!reset_i && yumi_i) begin
      checks++;
      if (!v_o) begin
        errors++;
        $display("FAIL yumi_legal: yumi with v_o=%b expected 1", v_o);
      end
    end
  end

  // Model: decode to a real value, ignore NaNs, break the +/-0 tie by sign.
  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 0);
  endfunction

  function automatic real h2r(input logic [15:0] x);
    int e = int'(x[14:10]);
    int m = int'(x[9:0]);
    real v;
    int  k;
    if (e == 31) return x[15] ? -1.0e30 : 1.0e30;
    if (e == 0) begin v = real'(m); k = -24; end
    else begin v = real'(1024 + m); k = e - 25; end
    while (k > 0) begin v = v * 2.0; k--; end
    while (k < 0) begin v = v / 2.0; k++; end
    return x[15] ? -v : v;
  endfunction

  function automatic bit less(input logic [15:0] a, input logic [15:0] b);
    real ra = h2r(a);
    real rb = h2r(b);
    if (ra != rb) return ra < rb;
    return a[15] && !b[15];
  endfunction

  task automatic model(input logic [15:0] q[$], output logic [15:0] mn, output logic [15:0] mx,
                       output logic inv);
    bit any = 0;
    mn = 16'h7E00; mx = 16'h7E00; inv = 0;
    foreach (q[i]) begin
      if (is_nan(q[i])) begin
        if (!q[i][9]) inv = 1;
      end else if (!any) begin
        mn = q[i]; mx = q[i]; any = 1;
      end else begin
        if (less(q[i], mn)) mn = q[i];
        if (less(mx, q[i])) mx = q[i];
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    v_i = 1; data_i = d; last_i = l;
    tick();
    v_i = 0; last_i = 0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                              input logic inv, input int cnt);
    chk({tag, ".v"}, v_o, 1);
    chk({tag, ".ready"}, ready_o, 0);
    chk({tag, ".min"}, min_o, mn);
    chk({tag, ".max"}, max_o, mx);
    chk({tag, ".inv"}, invalid_o, inv);
    chk({tag, ".count"}, count_o, cnt);
  endtask

  task automatic yumi_and_check(input string tag);
    yumi_i = 1;
    tick();
    yumi_i = 0;
    chk({tag, ".ready_after_yumi"}, ready_o, 1);
    chk({tag, ".count_after_yumi"}, count_o, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3, {16'h0, 16'h4000, 16'hC200, 16'h3C00}, 16'hC200, 16'h4000, 0, 3};
    vecs[1] = '{2, {16'h0, 16'h0, 16'h3C00, 16'h7E00}, 16'h3C00, 16'h3C00, 0, 2};
    vecs[2] = '{1, {16'h0, 16'h0, 16'h0, 16'h7D00}, 16'h7E00, 16'h7E00, 1, 1};
    vecs[3] = '{2, {16'h0, 16'h0, 16'h8000, 16'h0000}, 16'h8000, 16'h0000, 0, 2};
    vecs[4] = '{2, {16'h0, 16'h0, 16'hFC00, 16'h7C00}, 16'hFC00, 16'h7C00, 0, 2};
    vecs[5] = '{3, {16'h0, 16'h4000, 16'h3C00, 16'h7D00}, 16'h3C00, 16'h4000, 1, 3};

    reset_i = 1; v_i = 0; last_i = 0; yumi_i = 0; data_i = 0;
    tick(); tick();
    reset_i = 0;
    chk("reset.v", v_o, 0);
    chk("reset.ready", ready_o, 1);
    chk("reset.min", min_o, 16'h7E00);
    chk("reset.max", max_o, 16'h7E00);
    chk("reset.inv", invalid_o, 0);
    chk("reset.count", count_o, 0);

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) send(vecs[k].d[i], i == vecs[k].n - 1);
      check_result($sformatf("vec%0d", k), vecs[k].emin, vecs[k].emax, vecs[k].einv, vecs[k].ecnt);
      yumi_and_check($sformatf("vec%0d", k));
    end

    // Held result under backpressure; an offered element must not leak into the next reduction.
    send(16'h3C00, 1);
    v_i = 1; data_i = 16'h4000; last_i = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_result("hold", 16'h3C00, 16'h3C00, 0, 1);
    end
    last_i = 1; yumi_i = 1;
    tick();
    yumi_i = 0;
    chk("hold.ready_after_yumi", ready_o, 1);
    chk("hold.count_after_yumi", count_o, 0);
    tick();
    v_i = 0; last_i = 0;
    check_result("after_hold", 16'h4000, 16'h4000, 0, 1);
    yumi_and_check("after_hold");

    // Mid-stream reset, colliding with an offered element.
    send(16'hC200, 0);
    send(16'h3C00, 0);
    chk("pre_reset.count", count_o, 2);
    reset_i = 1; v_i = 1; data_i = 16'hC200;
    tick();
    reset_i = 0; v_i = 0;
    chk("midreset.count", count_o, 0);
    chk("midreset.min", min_o, 16'h7E00);
    chk("midreset.max", max_o, 16'h7E00);
    chk("midreset.v", v_o, 0);
    // last without valid does nothing
    last_i = 1; tick(); last_i = 0;
    chk("last_no_v.count", count_o, 0);
    send(16'h7C00, 1);
    check_result("post_reset", 16'h7C00, 16'h7C00, 0, 1);
    yumi_and_check("post_reset");

    // Random streams with idle gaps and delayed yumi.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] q[$];
      logic [15:0] mn, mx, x;
      logic        inv;
      int          n = $urandom_range(1, 7);
      q = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0: x = {1'($urandom), 5'h1f, 1'b1, 9'($urandom)};
          1: x = {1'($urandom), 5'h1f, 1'b0, 9'($urandom) | 9'h1};
          2: x = {1'($urandom), 15'h7C00};
          3: x = {1'($urandom), 15'h0};
          4: x = {1'($urandom), 5'h0, 10'($urandom)};
          default: x = 16'($urandom);
        endcase
        q.push_back(x);
        while ($urandom_range(0, 3) == 0) begin
          last_i = 1'($urandom);
          tick();
          last_i = 0;
        end
        send(x, i == n - 1);
      end
      model(q, mn, mx, inv);
      repeat ($urandom_range(0, 2)) tick();
      check_result($sformatf("rand%0d", r), mn, mx, inv, n);
      yumi_and_check($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/bsg_fpu_minmax_reduce.md
Name: bsg_fpu_minmax_reduce

Overview:
Streaming reduction stage built directly downstream of the FP compare unit (bsg_fpu_cmp).
- Accepts a stream of IEEE-style floats (default half precision) over a valid/ready handshake.
- Feeds each element, together with the running accumulators, through internal bsg_fpu_cmp instances.
- Holds the running min, max, sticky invalid flag and element count.
- Presents the reduced result on a valid/yumi output port when the element tagged last is accepted.
- Used for vector fmin/fmax reductions in the FPU datapath.

Parameters:
e_p, 5, exponent width; passed to the internal bsg_fpu_cmp.
m_p, 10, mantissa width; passed to the internal bsg_fpu_cmp.
count_width_p, 16, width of the element counter.
(width_lp = 1+e_p+m_p is derived, not a parameter.)

Ports:
clk_i  in  1  clock; all state updates on rising edge.
reset_i  in  1  synchronous, active-high reset.
v_i  in  1  input element valid.
data_i  in  width_lp  input float element.
last_i  in  1  marks final element of the current reduction; qualified by v_i.
ready_o  out  1  block can accept an element this cycle.
v_o  out  1  reduced result valid.
min_o  out  width_lp  reduced minimum.
max_o  out  width_lp  reduced maximum.
invalid_o  out  1  sticky OR of compare min_max_invalid across the reduction.
count_o  out  count_width_p  number of elements in the reduction.
yumi_i  in  1  consumer takes the result; legal only while v_o=1.

Behaviour:
Clock and reset:
- One clock, clk_i. reset_i is synchronous and active-high.

States:
- ACCUM: ready_o=1, v_o=0.
- DONE: ready_o=0, v_o=1.
- Reset enters ACCUM.
- Reset values: min_r=max_r=canonical qNaN (sign 0, exp all ones, mantissa MSB only; 0x7E00 at default), invalid_r=0, count_r=0, v_o=0.
- min_o/max_o/invalid_o/count_o are driven directly from registers in all states.

Accept and update:
- Accept when v_i & ready_o.
- On accept: min_r <= cmp(min_r, data_i).min_o; max_r <= cmp(max_r, data_i).max_o; invalid_r <= invalid_r | min_max_invalid of either cmp.
- The accumulator is the a operand, data_i the b operand. Two cmp instances (min path, max path) are permitted.
- On accept, count_r increments and saturates at all-ones.
- Throughput: one element per cycle in ACCUM.

NaN and zero handling (inherited from cmp, so no special first-element path):
- Canonical-NaN init means the first non-NaN element replaces it.
- An all-NaN stream yields canonical qNaN.
- Any sNaN sets invalid.
- -0 orders below +0: min of {+0,-0} is -0, max is +0.

Completion and handoff:
- Accept with last_i=1 moves to DONE. v_o rises the next cycle, with registers already holding the final values (latency 1 cycle from last accept).
- In DONE, v_i is ignored (ready_o=0).
- yumi_i in DONE returns to ACCUM and reinitialises: min_r/max_r to canonical NaN, invalid_r=0, count_r=0.
- ready_o=1 on the cycle after yumi. No element is accepted in the yumi cycle itself.
- yumi_i while v_o=0 is illegal; the bench asserts against it and RTL ignores it.
- last_i without v_i has no effect.
- Every reduction contains at least one element.

Reset mid-stream:
- Discards partial state immediately and returns to reset values.
- Reset dominates a simultaneous accept or yumi.

Test Plan:
- 0x3C00, 0xC200, 0x4000(last) back-to-back -> one cycle after last accept: v_o=1, min_o=0xC200, max_o=0x4000, invalid_o=0, count_o=3.
- 0x7E00, 0x3C00(last) -> min_o=max_o=0x3C00, invalid_o=0, count_o=2. Single 0x7D00(last) -> min_o=max_o=0x7E00, invalid_o=1, count_o=1.
- 0x0000, 0x8000(last) -> min_o=0x8000, max_o=0x0000. Also 0x7C00, 0xFC00(last) -> min_o=0xFC00, max_o=0x7C00.
- Backpressure: after result, hold yumi_i=0 for 5 cycles with v_i=1, data_i=0x4000 -> ready_o=0 throughout, outputs stable. Then yumi_i=1 -> ready_o=1 next cycle; the next reduction 0x4000(last) yields count_o=1 and does not include the earlier held element.
- Reset after 2 accepted elements (0xC200, 0x3C00) -> next cycle count_o=0, min_o=max_o=0x7E00, v_o=0. Then 0x7C00(last) -> min_o=max_o=0x7C00, count_o=1.
- Sticky invalid: 0x7D00, 0x3C00, 0x4000(last) -> min_o=0x3C00, max_o=0x4000, invalid_o=1, count_o=3.
